// File: rtl/umi_requester.sv
// rtl/umi_requester.sv - single-outstanding UMI request initiator
// Issues one local read/write/posted command as a UMI request and returns its completion.
module umi_requester #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int DW      = 256,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          loc_valid,
  output logic          loc_ready,
  input  logic          loc_write,
  input  logic          loc_posted,
  input  logic [AW-1:0] loc_addr,
  input  logic [AW-1:0] loc_srcaddr,
  input  logic [2:0]    loc_size,
  input  logic [7:0]    loc_len,
  input  logic [DW-1:0] loc_wrdata,
  output logic          loc_done,
  output logic [1:0]    loc_err,
  output logic [DW-1:0] loc_rddata,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LIM = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state;
  logic            cap_write;
  logic            cap_posted;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic            timeout_hit;
  logic            resp_match;
  logic            unused_resp;

  // Standard UMI command layout: opcode[4:0], size[7:5], len[15:8], eom[22].
  function automatic logic [CW-1:0] umi_pack(input logic [4:0] opcode,
                                             input logic [2:0] size,
                                             input logic [7:0] len,
                                             input logic       eom);
    logic [31:0] c;
    c       = '0;
    c[4:0]  = opcode;
    c[7:5]  = size;
    c[15:8] = len;
    c[22]   = eom;
    return CW'(c);
  endfunction

  assign cnt_nxt = (cnt == {CNTW{1'b1}}) ? cnt : cnt + CNTW'(1);
  // Second term covers TIMEOUT=1, where the limit is already met on the first wait cycle.
  assign timeout_hit = (TIMEOUT != 0) && ((cnt_nxt == CNT_LIM) || (cnt == CNT_LIM));

  // The held request srcaddr is the captured return address the response must target.
  assign resp_match = (uhost_resp_cmd[4:0] == (cap_write ? UMI_RESP_WRITE : UMI_RESP_READ)) &&
                      (uhost_resp_dstaddr == uhost_req_srcaddr);

  assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cap_write         <= 1'b0;
      cap_posted        <= 1'b0;
      cnt               <= '0;
      loc_ready         <= 1'b1;
      loc_done          <= 1'b0;
      loc_err           <= 2'b00;
      loc_rddata        <= '0;
      uhost_req_valid   <= 1'b0;
      uhost_req_cmd     <= '0;
      uhost_req_dstaddr <= '0;
      uhost_req_srcaddr <= '0;
      uhost_req_data    <= '0;
      uhost_resp_ready  <= 1'b1;
    end else begin
      loc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (loc_valid) begin
            cap_write         <= loc_write;
            cap_posted        <= loc_write & loc_posted;
            uhost_req_cmd     <= umi_pack(loc_write ? (loc_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE)
                                                    : UMI_REQ_READ,
                                          loc_size, loc_len, 1'b1);
            uhost_req_dstaddr <= loc_addr;
            uhost_req_srcaddr <= loc_srcaddr;
            uhost_req_data    <= loc_write ? loc_wrdata : '0;
            uhost_req_valid   <= 1'b1;
            loc_ready         <= 1'b0;
            state             <= REQ;
          end
        end
        REQ: begin
          if (uhost_req_ready) begin
            uhost_req_valid <= 1'b0;
            if (cap_posted) begin
              loc_err          <= 2'b00;
              loc_done         <= 1'b1;
              uhost_resp_ready <= 1'b0;
              state            <= DONE;
            end else begin
              cnt   <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (uhost_resp_valid) begin
            loc_err <= resp_match ? 2'b00 : 2'b01;
            if (resp_match && !cap_write) begin
              loc_rddata <= uhost_resp_data;
            end
            loc_done         <= 1'b1;
            uhost_resp_ready <= 1'b0;
            state            <= DONE;
          end else if (timeout_hit) begin
            loc_err          <= 2'b10;
            loc_done         <= 1'b1;
            uhost_resp_ready <= 1'b0;
            state            <= DONE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE: begin
          loc_ready        <= 1'b1;
          uhost_resp_ready <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          loc_ready        <= 1'b1;
          uhost_req_valid  <= 1'b0;
          uhost_resp_ready <= 1'b1;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umi_requester.sv
// tb/tb_umi_requester.sv - scoreboard bench for umi_requester
// Expected requests and completions are queued at stimulus time and checked as the DUT emits them.
module tb_umi_requester;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          loc_valid = 1'b0;
  logic          loc_ready;
  logic          loc_write = 1'b0;
  logic          loc_posted = 1'b0;
  logic [AW-1:0] loc_addr = '0;
  logic [AW-1:0] loc_srcaddr = '0;
  logic [2:0]    loc_size = '0;
  logic [7:0]    loc_len = '0;
  logic [DW-1:0] loc_wrdata = '0;
  logic          loc_done;
  logic [1:0]    loc_err;
  logic [DW-1:0] loc_rddata;
  logic          uhost_req_valid;
  logic [CW-1:0] uhost_req_cmd;
  logic [AW-1:0] uhost_req_dstaddr;
  logic [AW-1:0] uhost_req_srcaddr;
  logic [DW-1:0] uhost_req_data;
  logic          uhost_req_ready = 1'b1;
  logic          uhost_resp_valid = 1'b0;
  logic [CW-1:0] uhost_resp_cmd = '0;
  logic [AW-1:0] uhost_resp_dstaddr = '0;
  logic [AW-1:0] uhost_resp_srcaddr = '0;
  logic [DW-1:0] uhost_resp_data = '0;
  logic          uhost_resp_ready;

  umi_requester #(.CW(CW), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_write(loc_write), .loc_posted(loc_posted),
    .loc_addr(loc_addr), .loc_srcaddr(loc_srcaddr), .loc_size(loc_size), .loc_len(loc_len),
    .loc_wrdata(loc_wrdata), .loc_done(loc_done), .loc_err(loc_err), .loc_rddata(loc_rddata),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    op;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
    bit            has_rsp;
    rsp_t          rsp;
  } req_t;

  typedef struct {
    logic [1:0]    err;
    logic [DW-1:0] rd;
    int            lat;
  } exp_t;

  // mode: 0 good response, 1 wrong opcode, 2 wrong dstaddr, 3 no response
  typedef struct {
    bit            write;
    bit            posted;
    logic [AW-1:0] addr;
    logic [AW-1:0] src;
    logic [2:0]    size;
    logic [7:0]    len;
    logic [DW-1:0] wdata;
    int            mode;
    logic [DW-1:0] rdata;
  } txn_t;

  req_t reqq[$];
  exp_t expq[$];
  rsp_t rspq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs = 0;
  int force_low = 0;
  int rsp_gap = 0;
  bit rand_mode = 1'b0;
  bit rsp_hs = 1'b0;
  logic [DW-1:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic txn_t mk(bit write, bit posted, logic [AW-1:0] addr, logic [AW-1:0] src,
                              logic [2:0] size, logic [7:0] len, logic [DW-1:0] wdata,
                              int mode, logic [DW-1:0] rdata);
    txn_t t;
    t.write = write; t.posted = posted; t.addr = addr; t.src = src; t.size = size;
    t.len = len; t.wdata = wdata; t.mode = mode; t.rdata = rdata;
    return t;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    req_t q;
    rsp_t r;
    if (!reset) begin
      if (loc_done) begin
        if (expq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("done_err", loc_err, e.err);
          chk("done_rddata", loc_rddata, e.rd);
          chk("done_latency", cyc - last_hs, e.lat);
          chk("ready_low_at_done", loc_ready, 0);
          chk("resp_ready_low_at_done", uhost_resp_ready, 0);
        end
      end
      if (rsp_hs) begin
        void'(rspq.pop_front());
        uhost_resp_valid = 1'b0;
        rsp_hs = 1'b0;
      end
      if (!uhost_resp_valid && rspq.size() > 0) begin
        if (rsp_gap > 0) begin
          rsp_gap--;
        end else begin
          r = rspq[0];
          uhost_resp_cmd     = CW'(r.op) | 32'h0040_0000;
          uhost_resp_dstaddr = r.dst;
          uhost_resp_srcaddr = 64'h7777;
          uhost_resp_data    = r.data;
          uhost_resp_valid   = 1'b1;
        end
      end
      if (uhost_resp_valid && uhost_resp_ready) begin
        rsp_hs  = 1'b1;
        last_hs = cyc;
        rsp_gap = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end
      if (uhost_req_valid) begin
        if (force_low > 0) begin
          uhost_req_ready = 1'b0;
          force_low--;
        end else begin
          uhost_req_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (reqq.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          q = reqq[0];
          chk("req_cmd", uhost_req_cmd, q.cmd);
          chk("req_dstaddr", uhost_req_dstaddr, q.dst);
          chk("req_srcaddr", uhost_req_srcaddr, q.src);
          chk("req_data", uhost_req_data, q.data);
          if (uhost_req_ready) begin
            void'(reqq.pop_front());
            last_hs = cyc;
            if (q.has_rsp) rspq.push_back(q.rsp);
          end
        end
      end else begin
        uhost_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic send(input txn_t t);
    req_t q;
    exp_t e;
    logic [4:0] op;
    int n;
    op = t.write ? (t.posted ? 5'h05 : 5'h03) : 5'h01;
    q.cmd  = CW'(op) | (CW'(t.size) << 5) | (CW'(t.len) << 8) | (32'h1 << 22);
    q.dst  = t.addr;
    q.src  = t.src;
    q.data = t.write ? t.wdata : '0;
    q.has_rsp  = !(t.write && t.posted) && (t.mode != 3);
    q.rsp.op   = t.write ? 5'h04 : 5'h02;
    q.rsp.dst  = t.src;
    q.rsp.data = t.rdata;
    if (t.mode == 1) q.rsp.op = t.write ? 5'h02 : 5'h04;
    if (t.mode == 2) q.rsp.dst = t.src + 64'h4;
    if (t.write && t.posted) begin
      e.err = 2'b00; e.lat = 1;
    end else if (t.mode == 3) begin
      e.err = 2'b10; e.lat = TO;
    end else if (t.mode == 0) begin
      e.err = 2'b00; e.lat = 1;
      if (!t.write) exp_rd = t.rdata;
    end else begin
      e.err = 2'b01; e.lat = 1;
    end
    e.rd = exp_rd;
    @(negedge clk);
    loc_write = t.write; loc_posted = t.posted; loc_addr = t.addr; loc_srcaddr = t.src;
    loc_size = t.size; loc_len = t.len; loc_wrdata = t.wdata; loc_valid = 1'b1;
    n = 0;
    while (!loc_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 0, 1);
      loc_valid = 1'b0;
    end else begin
      reqq.push_back(q);
      expq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      loc_valid = 1'b0;
      chk("ready_low_after_accept", loc_ready, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() > 0 || reqq.size() > 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", expq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rsp_t late;
    bit w;
    repeat (3) @(negedge clk);
    chk("rst_loc_ready", loc_ready, 1);
    chk("rst_req_valid", uhost_req_valid, 0);
    chk("rst_resp_ready", uhost_resp_ready, 1);
    chk("rst_loc_done", loc_done, 0);
    chk("rst_loc_err", loc_err, 0);
    chk("rst_rddata", loc_rddata, 0);
    chk("rst_req_cmd", uhost_req_cmd, 0);
    chk("rst_req_dst", uhost_req_dstaddr, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_loc_ready", loc_ready, 1);

    send(mk(0, 0, 64'h1000, 64'hA0, 3'd2, 8'd0, '0, 0, 256'hDEADBEEF));
    drain();

    force_low = 3;
    send(mk(1, 1, 64'h2000, 64'hA0, 3'd0, 8'd0, 256'h55, 0, '0));
    drain();

    send(mk(1, 0, 64'h3000, 64'hA0, 3'd2, 8'd0, 256'h1234, 1, 256'hBAD1));
    send(mk(1, 0, 64'h3008, 64'hA0, 3'd2, 8'd0, 256'h5678, 2, 256'hBAD2));
    send(mk(0, 0, 64'h3010, 64'hA0, 3'd3, 8'd1, '0, 2, 256'hBAD3));
    drain();

    send(mk(0, 0, 64'h4000, 64'hA0, 3'd2, 8'd0, '0, 3, '0));
    drain();
    late.op = 5'h02; late.dst = 64'hA0; late.data = 256'hFEED;
    rspq.push_back(late);
    repeat (10) @(negedge clk);
    chk("late_rsp_consumed", rspq.size(), 0);
    chk("late_rsp_rddata", loc_rddata, exp_rd);

    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      send(mk(w, w & 1'($urandom_range(0, 1)), {32'h0, $urandom}, {32'h0, $urandom},
              3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              0, {224'h0, $urandom}));
    end
    drain();
    rand_mode = 1'b0;

    send(mk(0, 0, 64'h5000, 64'hB0, 3'd2, 8'd0, '0, 3, '0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_loc_ready", loc_ready, 1);
    chk("midrst_req_valid", uhost_req_valid, 0);
    chk("midrst_loc_done", loc_done, 0);
    @(negedge clk);
    chk("midrst_resp_ready", uhost_resp_ready, 1);
    chk("midrst_rddata", loc_rddata, 0);
    void'(expq.pop_back());
    exp_rd = '0;
    reset = 1'b0;
    late.op = 5'h02; late.dst = 64'hB0; late.data = 256'hABCD;
    rspq.push_back(late);
    repeat (8) @(negedge clk);
    chk("abandoned_rsp_consumed", rspq.size(), 0);
    chk("abandoned_rsp_rddata", loc_rddata, 0);

    send(mk(0, 0, 64'h6000, 64'hC0, 3'd2, 8'd0, '0, 0, 256'hCAFEF00D));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/umi_requester.md
# umi_requester

Single-outstanding UMI request initiator, the host-side counterpart of the UMI simple endpoint. It accepts one read, write or posted-write command from a local client and issues it as a UMI request packet. It then waits for the matching response, with an optional timeout, and returns read data and completion status to the client. It sits between a local controller (CPU shim, DMA, test sequencer) and a UMI host port.

## Interface
- CW, 32, command width
- AW, 64, address width
- DW, 256, data width
- TIMEOUT, 0, response timeout in cycles (0 = disabled)
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- loc_valid  in  1  local command valid
- loc_ready  out  1  local command accepted when valid&ready
- loc_write  in  1  1=write, 0=read
- loc_posted  in  1  with loc_write: posted write (no response)
- loc_addr  in  AW  target address
- loc_srcaddr  in  AW  return address placed in srcaddr
- loc_size  in  3  size field
- loc_len  in  8  len field
- loc_wrdata  in  DW  write data
- loc_done  out  1  one-cycle completion pulse
- loc_err  out  2  completion status, valid with loc_done: 00 ok, 01 mismatch, 10 timeout
- loc_rddata  out  DW  read data, valid with loc_done
- uhost_req_valid/cmd/dstaddr/srcaddr/data  out  1/CW/AW/AW/DW  UMI request
- uhost_req_ready  in  1
- uhost_resp_valid/cmd/dstaddr/srcaddr/data  in  1/CW/AW/AW/DW  UMI response
- uhost_resp_ready  out  1

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - loc_ready=1.
  - On loc_valid, capture write/posted/addr/srcaddr/size/len/wrdata and go to REQ.
- REQ:
  - uhost_req_valid=1. All request fields are registered and held stable until uhost_req_ready.
  - On handshake, a posted write goes to DONE with err=00. A read or non-posted write goes to WAIT and clears the timeout counter.
- Request cmd is built with umi_pack:
  - opcode: UMI_REQ_READ (0x01), UMI_REQ_WRITE (0x03) or UMI_REQ_POSTED (0x05).
  - size and len come from the captured fields; eom=1; all other fields are 0.
- Request addresses and data: dstaddr=loc_addr, srcaddr=loc_srcaddr. uhost_req_data carries wrdata for writes and 0 for reads.
- WAIT:
  - Waits for a response handshake; the timeout counter increments each cycle.
  - Response checks: the opcode must equal UMI_RESP_READ (0x02) for a read or UMI_RESP_WRITE (0x04) for a write, and resp_dstaddr must equal the captured srcaddr. Either mismatch gives err=01; otherwise err=00.
  - On a read response, latch resp_data into loc_rddata. For a write or a mismatch, loc_rddata keeps its previous value.
  - Go to DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no response, go to DONE with err=10.
- DONE: loc_done=1 for exactly one cycle, then go to IDLE.
- uhost_resp_ready=1 in IDLE, REQ and WAIT, and 0 in DONE. Responses handshaken outside WAIT are dropped, including late responses after a timeout.
- Counter width: clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: loc_ready=1, uhost_req_valid=0, uhost_resp_ready=1, loc_done=0, loc_err=0, loc_rddata=0, cmd/addr/data outputs=0.
- Accept at cycle N puts uhost_req_valid high at N+1; minimum command-to-request latency is 1 cycle.
- Posted write with req_ready high: accept at N, request handshake at N+1, loc_done at N+2; next accept possible at N+3.
- Read with zero-latency responder: response handshake at cycle M, loc_done and loc_rddata at M+1.
- loc_ready is registered from state; a command can never be accepted in the same cycle a completion is reported.
- Timeout and response in the same cycle: the response wins.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs at reset values. The outstanding transaction is abandoned and its later response is dropped.

## Test plan
- Read: addr=0x1000, srcaddr=0xA0, size=2, len=0 -> request cmd opcode 0x01, dstaddr 0x1000, srcaddr 0xA0. Respond with opcode 0x02, dstaddr 0xA0, data 0xDEADBEEF -> loc_done one cycle later, err=00, loc_rddata=0xDEADBEEF.
- Posted write: data 0x55 to 0x2000, req_ready held low 3 cycles -> request fields stable during the stall; loc_done 1 cycle after the handshake, err=00; no response awaited.
- Non-posted write answered with opcode 0x02 or dstaddr 0xA4 -> err=01, loc_rddata unchanged.
- TIMEOUT=8, read with no response -> loc_done with err=10 exactly 8 cycles after the request handshake. A late response then handshakes in IDLE and produces no loc_done.
- Back-to-back read/write/posted with random req_ready/resp_valid gaps -> one completion per command, in order; loc_ready low from accept to loc_done+1.
- Assert reset while in WAIT -> next cycle state IDLE, loc_ready=1, uhost_req_valid=0, no loc_done.
